// File: rtl/inst_fetch_req_if.sv
// Instruction fetch request bus bundle.
// Groups the redirect input, the instruction-memory request/response channel and the
// fetch-unit delivery channel used by inst_fetch_req.
//   master : the fetch request engine (drives mem_req_o/mem_addr_o and ifu_* outputs)
//   slave  : the environment (memory + fetch unit + redirect source)
interface inst_fetch_req_if;
    logic        jumpFlag_i;
    logic [31:0] jumpAddr_i;
    logic        ifu_ready_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        ifu_valid_o;
    logic [31:0] ifu_inst_o;
    logic [31:0] ifu_instAddr_o;

    modport master (
        input  jumpFlag_i, jumpAddr_i, ifu_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output mem_req_o, mem_addr_o, ifu_valid_o, ifu_inst_o, ifu_instAddr_o
    );

    modport slave (
        output jumpFlag_i, jumpAddr_i, ifu_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  mem_req_o, mem_addr_o, ifu_valid_o, ifu_inst_o, ifu_instAddr_o
    );
endinterface

// File: rtl/inst_fetch_req.sv
// Instruction fetch request engine.
// Issues sequential instruction-memory reads starting at RESET_PC, keeps the addresses of
// in-flight reads, buffers in-order responses and hands {instruction, address} pairs to
// the fetch unit. A redirect (jumpFlag_i) flushes buffered data and discards every
// response still owed by the memory for requests issued before the redirect.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : inst_fetch_req_if.master (redirect, memory channel, fetch-unit channel)
// Total of in-flight reads, buffered responses and pending discards never exceeds
// MAX_CREDIT, which is what keeps both internal FIFOs from overflowing.
module inst_fetch_req #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned MAX_CREDIT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    inst_fetch_req_if.master   bus
);

    localparam int unsigned CNT_W = $clog2(MAX_CREDIT + 1);
    localparam int unsigned PTR_W = (MAX_CREDIT > 1) ? $clog2(MAX_CREDIT) : 1;
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] CREDIT_LIMIT = SUM_W'(MAX_CREDIT);
    localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(MAX_CREDIT - 1);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;

    // Outstanding-address FIFO (storage is unreset; only pointers/count matter)
    logic [31:0]      out_addr_q [MAX_CREDIT];
    logic [PTR_W-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    // Response buffer
    logic [31:0]      buf_data_q [MAX_CREDIT];
    logic [31:0]      buf_addr_q [MAX_CREDIT];
    logic [PTR_W-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [CNT_W-1:0] buf_cnt_q, buf_cnt_d;

    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             jump;
    logic [SUM_W-1:0] credit_sum;
    logic [SUM_W-1:0] drop_sum;
    logic             mem_req;
    logic             grant;
    logic             draining;
    logic             rsp_any;
    logic             rsp_keep;
    logic             rsp_drop;
    logic             ifu_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign jump       = bus.jumpFlag_i;
    assign credit_sum = SUM_W'(out_cnt_q) + SUM_W'(buf_cnt_q) + SUM_W'(drop_cnt_q);
    assign mem_req    = (state_q != ST_BOOT) && !jump && (credit_sum < CREDIT_LIMIT);
    // The request is withdrawn during a jump, so a grant only counts while it is asserted.
    assign grant      = mem_req && bus.mem_gnt_i;
    assign draining   = (drop_cnt_q != '0);
    // Ignore a response that cannot belong to any issued request (e.g. straggler after reset).
    assign rsp_any    = bus.mem_rvalid_i && (draining || (out_cnt_q != '0));
    assign rsp_keep   = rsp_any && !jump && !draining;
    assign rsp_drop   = rsp_any && !jump && draining;
    assign ifu_pop    = (buf_cnt_q != '0) && bus.ifu_ready_i && !jump;
    assign drop_sum   = SUM_W'(drop_cnt_q) + SUM_W'(out_cnt_q) + SUM_W'(grant)
                      - SUM_W'(rsp_any);

    assign bus.mem_req_o      = mem_req;
    assign bus.mem_addr_o     = pc_q;
    assign bus.ifu_valid_o    = ifu_pop;
    assign bus.ifu_inst_o     = buf_data_q[buf_rd_q];
    assign bus.ifu_instAddr_o = buf_addr_q[buf_rd_q];

    always_comb begin
        pc_d       = pc_q;
        out_wr_d   = out_wr_q;
        out_rd_d   = out_rd_q;
        out_cnt_d  = out_cnt_q;
        buf_wr_d   = buf_wr_q;
        buf_rd_d   = buf_rd_q;
        buf_cnt_d  = buf_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (jump) begin
            pc_d       = {bus.jumpAddr_i[31:2], 2'b00};
            out_wr_d   = '0;
            out_rd_d   = '0;
            out_cnt_d  = '0;
            buf_wr_d   = '0;
            buf_rd_d   = '0;
            buf_cnt_d  = '0;
            drop_cnt_d = CNT_W'(drop_sum);
        end else begin
            if (grant) begin
                pc_d     = pc_q + 32'd4;
                out_wr_d = ptr_inc(out_wr_q);
            end
            if (rsp_keep) begin
                out_rd_d = ptr_inc(out_rd_q);
                buf_wr_d = ptr_inc(buf_wr_q);
            end
            if (ifu_pop) begin
                buf_rd_d = ptr_inc(buf_rd_q);
            end
            out_cnt_d  = out_cnt_q + CNT_W'(grant) - CNT_W'(rsp_keep);
            buf_cnt_d  = buf_cnt_q + CNT_W'(rsp_keep) - CNT_W'(ifu_pop);
            drop_cnt_d = drop_cnt_q - CNT_W'(rsp_drop);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_FETCH;
            ST_DRAIN: state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            out_cnt_q  <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            buf_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_wr_q   <= out_wr_d;
            out_rd_q   <= out_rd_d;
            out_cnt_q  <= out_cnt_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
            buf_cnt_q  <= buf_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            out_addr_q[out_wr_q] <= pc_q;
        end
        if (rsp_keep) begin
            buf_data_q[buf_wr_q] <= bus.mem_rdata_i;
            buf_addr_q[buf_wr_q] <= out_addr_q[out_rd_q];
        end
    end

endmodule
